// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divider.
// Provides XLEN, the operation and state encodings, special-case constants
// and a small two's-complement magnitude helper.
package div_pkg;

  localparam int XLEN = 32;

  // Number of shift/subtract iterations for one full quotient.
  localparam logic [5:0] ITERS = 6'd32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  // Conditional two's-complement negate; used both for taking magnitudes
  // and for restoring the sign of the result.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/divu_iter.sv
// Unsigned radix-2 restoring divider datapath, one quotient bit per step.
// Ports: load/dividend/divisor start a new division; step advances one
// iteration; quo/rem are the running results; last is high once all 32 steps are done.
module divu_iter
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            last
);

  logic [XLEN-1:0] dvsr;
  logic [5:0]      cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // The shifted remainder needs 33 bits: rem < divisor < 2^32, so 2*rem+1
  // can exceed 32 bits. A clear trial MSB means the subtraction fits.
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr};
  assign last    = (cnt == ITERS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem  <= '0;
      quo  <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (load) begin
      rem  <= '0;
      quo  <= dividend;
      dvsr <= divisor;
      cnt  <= '0;
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: FSM, sign handling, special cases, write-back.
// Ports: start/op/dividend/divisor/rd request an operation in IDLE; busy stalls
// the core; done/we pulse one cycle with result/waddr toward the register file.
module div_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [XLEN-1:0] result,
  output logic [4:0]      waddr
);

  div_state_t      state, state_nxt;
  div_op_t         op_e;
  logic            accept, is_signed, is_rem;
  logic            a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  logic            is_rem_q, neg_quo_q, neg_rem_q;
  logic [4:0]      rd_q;

  logic [XLEN-1:0] quo, rem;
  logic            last, load, step;

  assign op_e      = div_op_t'(op);
  assign is_signed = (op_e == DIV) || (op_e == REM);
  assign is_rem    = (op_e == REM) || (op_e == REMU);
  assign a_neg     = is_signed && dividend[XLEN-1];
  assign b_neg     = is_signed && divisor[XLEN-1];
  assign a_mag     = neg_if(dividend, a_neg);
  assign b_mag     = neg_if(divisor, b_neg);

  // Cases the iteration would get wrong (or that RV32M defines explicitly)
  // are answered directly at the accept edge.
  assign div_zero    = (divisor == '0);
  assign overflow    = is_signed && (dividend == INT_MIN) && (divisor == '1);
  assign special     = div_zero || overflow;
  assign special_res = div_zero ? (is_rem ? dividend : DIV_BY_ZERO_Q)
                                : (is_rem ? '0 : INT_MIN);

  assign accept = (state == IDLE) && start;
  assign load   = accept && !special;
  assign step   = (state == CALC) && !last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      result    <= '0;
      waddr     <= '0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q      <= rd;
        is_rem_q  <= is_rem;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        if (special) begin
          result <= special_res;
          waddr  <= rd;
        end
      end
      // Results update only on DONE entry so they hold between operations.
      if ((state == CALC) && last) begin
        result <= is_rem_q ? neg_if(rem, neg_rem_q) : neg_if(quo, neg_quo_q);
        waddr  <= rd_q;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign we   = done;

  divu_iter u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo),
    .rem      (rem),
    .last     (last)
  );

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  waddr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .rd       (rd),
    .busy     (busy),
    .done     (done),
    .we       (we),
    .result   (result),
    .waddr    (waddr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its write-back. exp_lat is the
  // number of edges after the accept edge at which done is first seen.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b; rd = r;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    while (!done && k < 60) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " waddr"}, {27'd0, waddr}, {27'd0, r});
    check({tag, " we"}, {31'd0, we}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done drop"}, {31'd0, done}, 32'd0);
    check({tag, " busy drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    int pulses;
    int first_k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst we", {31'd0, we}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst waddr", {27'd0, waddr}, 32'd0);

    // Normal path
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 33);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'd1, 33);
    run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 33);
    run_op("div min/2", 2'b00, 32'h8000_0000, 32'd2, 5'd8, 32'hC000_0000, 33);
    run_op("remu big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 5'd9, 32'h7FFF_FFFF, 33);
    run_op("divu big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 32'd1, 33);

    // Fast path
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 0);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 5'd11, 32'd5, 0);
    run_op("rem -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 0);

    // Second start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd = 5'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    first_k = -1;
    for (k = 0; k <= 45; k++) begin
      if (k == 9) begin
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          check("ign result", result, 32'd14);
          check("ign waddr", {27'd0, waddr}, 32'd5);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("ign pulses", pulses, 32'd1);
    check("ign latency", first_k, 32'd33);

    // Reset mid-CALC aborts with no write-back
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd = 5'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort we", {31'd0, we}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort waddr", {27'd0, waddr}, 32'd0);
    pulses = 0;
    for (k = 0; k < 40; k++) begin
      if (done || busy) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort quiet", pulses, 32'd0);
    run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 5'd7, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
